// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - carries fetch predictions to EX, resolves them, flushes and trains the predictor
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_IF_valid,
    input  logic [31:0]      i_IF_pc,
    input  logic [31:0]      i_IF_pred_pc,
    input  logic             i_IF_pred_taken,
    input  logic             i_stall,
    input  logic [31:0]      i_EX_inst,
    input  logic             i_EX_brc_taken,
    input  logic [31:0]      i_alu_data,
    output logic             o_flush,
    output logic [31:0]      o_redirect_pc,
    output logic             o_upd_valid,
    output logic [31:0]      o_upd_pc,
    output logic [31:0]      o_upd_target,
    output logic             o_upd_taken,
    output logic             o_upd_inval,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mis_cnt
);

    localparam logic [4:0]       OP_BRANCH = 5'b11000;
    localparam logic [4:0]       OP_JAL    = 5'b11011;
    localparam logic [4:0]       OP_JALR   = 5'b11001;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic        d_valid_q, d_valid_d, d_pred_taken_q, d_pred_taken_d;
    logic [31:0] d_pc_q, d_pc_d, d_pred_pc_q, d_pred_pc_d;
    logic        e_valid_q, e_valid_d, e_pred_taken_q, e_pred_taken_d;
    logic [31:0] e_pc_q, e_pc_d, e_pred_pc_q, e_pred_pc_d;

    logic             upd_valid_q, upd_valid_d, upd_inval_q, upd_inval_d;
    logic             upd_taken_q, upd_taken_d;
    logic [31:0]      upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

    logic        is_branch, is_jal, is_jalr, is_cf, actual_taken, mispredict, flush;
    logic [31:0] resolved_target, seq_pc, actual_next;

    logic unused_bits;
    assign unused_bits = ^{i_EX_inst[31:7], i_EX_inst[1:0], i_alu_data[1:0]};

    always_comb begin
        is_branch       = (i_EX_inst[6:2] == OP_BRANCH);
        is_jal          = (i_EX_inst[6:2] == OP_JAL);
        is_jalr         = (i_EX_inst[6:2] == OP_JALR);
        is_cf           = is_branch | is_jal | is_jalr;
        actual_taken    = is_jal | is_jalr | (is_branch & i_EX_brc_taken);
        resolved_target = {i_alu_data[31:2], 2'b00};
        seq_pc          = e_pc_q + 32'd4;
        actual_next     = actual_taken ? resolved_target : seq_pc;
        // A non-control-flow instruction only mispredicts when the BTB falsely hit on it.
        mispredict      = is_cf ? (actual_next != e_pred_pc_q) : e_pred_taken_q;
        // Reset masks the flush so a squash in progress is discarded cleanly.
        flush           = e_valid_q & mispredict & ~i_rst;
    end

    always_comb begin
        d_valid_d      = d_valid_q;
        d_pc_d         = d_pc_q;
        d_pred_pc_d    = d_pred_pc_q;
        d_pred_taken_d = d_pred_taken_q;
        e_valid_d      = 1'b0;
        e_pc_d         = e_pc_q;
        e_pred_pc_d    = e_pred_pc_q;
        e_pred_taken_d = e_pred_taken_q;
        if (flush) begin
            d_valid_d = 1'b0;
        end else if (!i_stall) begin
            d_valid_d      = i_IF_valid;
            d_pc_d         = i_IF_pc;
            d_pred_pc_d    = i_IF_pred_pc;
            d_pred_taken_d = i_IF_pred_taken;
            e_valid_d      = d_valid_q;
            e_pc_d         = d_pc_q;
            e_pred_pc_d    = d_pred_pc_q;
            e_pred_taken_d = d_pred_taken_q;
        end

        upd_valid_d  = e_valid_q & is_cf;
        upd_inval_d  = e_valid_q & ~is_cf & e_pred_taken_q;
        upd_pc_d     = (upd_valid_d | upd_inval_d) ? e_pc_q : upd_pc_q;
        upd_target_d = upd_valid_d ? resolved_target : upd_target_q;
        upd_taken_d  = upd_valid_d ? actual_taken : upd_taken_q;

        br_cnt_d  = (upd_valid_d && br_cnt_q != CNT_MAX) ? br_cnt_q + CNT_ONE : br_cnt_q;
        mis_cnt_d = (flush && mis_cnt_q != CNT_MAX) ? mis_cnt_q + CNT_ONE : mis_cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            d_valid_q      <= 1'b0;
            d_pc_q         <= '0;
            d_pred_pc_q    <= '0;
            d_pred_taken_q <= 1'b0;
            e_valid_q      <= 1'b0;
            e_pc_q         <= '0;
            e_pred_pc_q    <= '0;
            e_pred_taken_q <= 1'b0;
            upd_valid_q    <= 1'b0;
            upd_inval_q    <= 1'b0;
            upd_pc_q       <= '0;
            upd_target_q   <= '0;
            upd_taken_q    <= 1'b0;
            br_cnt_q       <= '0;
            mis_cnt_q      <= '0;
        end else begin
            d_valid_q      <= d_valid_d;
            d_pc_q         <= d_pc_d;
            d_pred_pc_q    <= d_pred_pc_d;
            d_pred_taken_q <= d_pred_taken_d;
            e_valid_q      <= e_valid_d;
            e_pc_q         <= e_pc_d;
            e_pred_pc_q    <= e_pred_pc_d;
            e_pred_taken_q <= e_pred_taken_d;
            upd_valid_q    <= upd_valid_d;
            upd_inval_q    <= upd_inval_d;
            upd_pc_q       <= upd_pc_d;
            upd_target_q   <= upd_target_d;
            upd_taken_q    <= upd_taken_d;
            br_cnt_q       <= br_cnt_d;
            mis_cnt_q      <= mis_cnt_d;
        end
    end

    assign o_flush       = flush;
    assign o_redirect_pc = flush ? actual_next : 32'd0;
    assign o_upd_valid   = upd_valid_q;
    assign o_upd_inval   = upd_inval_q;
    assign o_upd_pc      = upd_pc_q;
    assign o_upd_target  = upd_target_q;
    assign o_upd_taken   = upd_taken_q;
    assign o_br_cnt      = br_cnt_q;
    assign o_mis_cnt     = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed bench with a per-cycle reference model of branch resolution
module tb_branch_resolve_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] BNE  = 32'h0000_1063;
    localparam logic [31:0] JALR = 32'h0000_0067;
    localparam logic [31:0] ADDI = 32'h0000_0013;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_IF_valid = 1'b0, i_IF_pred_taken = 1'b0, i_stall = 1'b0, i_EX_brc_taken = 1'b0;
    logic [31:0]      i_IF_pc = '0, i_IF_pred_pc = '0, i_EX_inst = '0, i_alu_data = '0;
    logic             o_flush, o_upd_valid, o_upd_taken, o_upd_inval;
    logic [31:0]      o_redirect_pc, o_upd_pc, o_upd_target;
    logic [CNT_W-1:0] o_br_cnt, o_mis_cnt;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_IF_valid(i_IF_valid), .i_IF_pc(i_IF_pc), .i_IF_pred_pc(i_IF_pred_pc),
        .i_IF_pred_taken(i_IF_pred_taken), .i_stall(i_stall),
        .i_EX_inst(i_EX_inst), .i_EX_brc_taken(i_EX_brc_taken), .i_alu_data(i_alu_data),
        .o_flush(o_flush), .o_redirect_pc(o_redirect_pc),
        .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc), .o_upd_target(o_upd_target),
        .o_upd_taken(o_upd_taken), .o_upd_inval(o_upd_inval),
        .o_br_cnt(o_br_cnt), .o_mis_cnt(o_mis_cnt)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the instructions in flight and the architectural results they must produce.
    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        bit          pred_taken;
    } slot_t;

    slot_t       in_id, in_ex;
    bit          m_upd_valid, m_upd_inval, m_upd_taken;
    logic [31:0] m_upd_pc, m_upd_target;
    int          m_br, m_mis;

    bit          cf, taken, m_flush;
    logic [31:0] target, next_pc;

    always @(negedge i_clk) begin
        cf      = (i_EX_inst[6:0] == 7'h63) || (i_EX_inst[6:0] == 7'h67) || (i_EX_inst[6:0] == 7'h6f);
        taken   = (i_EX_inst[6:0] == 7'h67) || (i_EX_inst[6:0] == 7'h6f) ||
                  ((i_EX_inst[6:0] == 7'h63) && i_EX_brc_taken);
        target  = i_alu_data & 32'hFFFF_FFFC;
        next_pc = taken ? target : in_ex.pc + 32'd4;
        m_flush = !i_rst && in_ex.valid && (cf ? (next_pc != in_ex.pred_pc) : in_ex.pred_taken);

        if (armed) begin
            chk("flush", {31'd0, o_flush}, {31'd0, m_flush});
            chk("redirect_pc", o_redirect_pc, m_flush ? next_pc : 32'd0);
            chk("upd_valid", {31'd0, o_upd_valid}, {31'd0, m_upd_valid});
            chk("upd_inval", {31'd0, o_upd_inval}, {31'd0, m_upd_inval});
            chk("upd_pc", o_upd_pc, m_upd_pc);
            chk("upd_target", o_upd_target, m_upd_target);
            chk("upd_taken", {31'd0, o_upd_taken}, {31'd0, m_upd_taken});
            chk("br_cnt", {28'd0, o_br_cnt}, m_br);
            chk("mis_cnt", {28'd0, o_mis_cnt}, m_mis);
        end

        if (i_rst) begin
            in_id = '{0, 0, 0, 0};
            in_ex = '{0, 0, 0, 0};
            m_upd_valid = 0; m_upd_inval = 0; m_upd_taken = 0;
            m_upd_pc = 0; m_upd_target = 0; m_br = 0; m_mis = 0;
        end else begin
            m_upd_valid = in_ex.valid && cf;
            m_upd_inval = in_ex.valid && !cf && in_ex.pred_taken;
            if (m_upd_valid || m_upd_inval) m_upd_pc = in_ex.pc;
            if (m_upd_valid) begin
                m_upd_target = target;
                m_upd_taken  = taken;
                m_br = (m_br >= CMAX) ? CMAX : m_br + 1;
            end
            if (m_flush) m_mis = (m_mis >= CMAX) ? CMAX : m_mis + 1;
            if (m_flush) begin
                in_id.valid = 0;
                in_ex.valid = 0;
            end else if (i_stall) begin
                in_ex.valid = 0;
            end else begin
                in_ex = in_id;
                in_id = '{i_IF_valid, i_IF_pc, i_IF_pred_pc, i_IF_pred_taken};
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] inst, input logic brc, input logic [31:0] alu);
        i_EX_inst = inst;
        i_EX_brc_taken = brc;
        i_alu_data = alu;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] pp, input logic pt);
        i_IF_valid = 1'b1;
        i_IF_pc = pc;
        i_IF_pred_pc = pp;
        i_IF_pred_taken = pt;
        step();
        i_IF_valid = 1'b0;
        i_IF_pred_taken = 1'b0;
    endtask

    initial begin
        step();
        armed = 1'b1;
        step();
        chk("reset_br_cnt", {28'd0, o_br_cnt}, 32'd0);
        chk("reset_upd_valid", {31'd0, o_upd_valid}, 32'd0);
        i_rst = 1'b0;

        // not-taken BEQ, correctly predicted
        set_ex(BEQ, 1'b0, 32'h1F0);
        fetch(32'h100, 32'h104, 1'b0);
        step();
        chk("beq_flush", {31'd0, o_flush}, 32'd0);
        step();
        chk("beq_upd_valid", {31'd0, o_upd_valid}, 32'd1);
        chk("beq_upd_taken", {31'd0, o_upd_taken}, 32'd0);
        chk("beq_upd_pc", o_upd_pc, 32'h100);
        chk("beq_br_cnt", {28'd0, o_br_cnt}, 32'd1);
        chk("beq_mis_cnt", {28'd0, o_mis_cnt}, 32'd0);
        step();
        chk("beq_upd_pulse", {31'd0, o_upd_valid}, 32'd0);

        // taken BNE mispredicted; the wrong-path fetch behind it must be squashed
        set_ex(BNE, 1'b1, 32'h180);
        fetch(32'h200, 32'h204, 1'b0);
        fetch(32'h204, 32'h990, 1'b0);
        chk("bne_flush", {31'd0, o_flush}, 32'd1);
        chk("bne_redirect", o_redirect_pc, 32'h180);
        step();
        chk("bne_squash1", {31'd0, o_flush}, 32'd0);
        chk("bne_mis_cnt", {28'd0, o_mis_cnt}, 32'd1);
        chk("bne_upd_target", o_upd_target, 32'h180);
        step();
        chk("bne_squash2", {31'd0, o_flush}, 32'd0);

        // false BTB hit on ADDI
        set_ex(ADDI, 1'b0, 32'h0);
        fetch(32'h300, 32'h500, 1'b1);
        step();
        chk("addi_flush", {31'd0, o_flush}, 32'd1);
        chk("addi_redirect", o_redirect_pc, 32'h304);
        step();
        chk("addi_inval", {31'd0, o_upd_inval}, 32'd1);
        chk("addi_upd_valid", {31'd0, o_upd_valid}, 32'd0);
        chk("addi_upd_pc", o_upd_pc, 32'h300);
        chk("addi_br_cnt", {28'd0, o_br_cnt}, 32'd2);
        chk("addi_mis_cnt", {28'd0, o_mis_cnt}, 32'd2);
        step();
        chk("addi_inval_pulse", {31'd0, o_upd_inval}, 32'd0);

        // JALR with low target bits masked off
        set_ex(JALR, 1'b0, 32'h803);
        fetch(32'h400, 32'h800, 1'b0);
        step();
        chk("jalr_flush", {31'd0, o_flush}, 32'd0);
        step();
        chk("jalr_upd_target", o_upd_target, 32'h800);
        chk("jalr_upd_taken", {31'd0, o_upd_taken}, 32'd1);
        chk("jalr_br_cnt", {28'd0, o_br_cnt}, 32'd3);

        // two stall cycles while the branch sits in D: resolves at N+4
        set_ex(BEQ, 1'b1, 32'h700);
        fetch(32'h600, 32'h700, 1'b0);
        i_stall = 1'b1;
        step();
        step();
        i_stall = 1'b0;
        chk("stall_no_upd", {31'd0, o_upd_valid}, 32'd0);
        chk("stall_br_hold", {28'd0, o_br_cnt}, 32'd3);
        step();
        step();
        chk("stall_upd_valid", {31'd0, o_upd_valid}, 32'd1);
        chk("stall_upd_pc", o_upd_pc, 32'h600);
        chk("stall_br_cnt", {28'd0, o_br_cnt}, 32'd4);

        // flush coincident with a stall still clears D
        set_ex(BNE, 1'b1, 32'h180);
        fetch(32'h200, 32'h204, 1'b0);
        fetch(32'h204, 32'h990, 1'b0);
        i_stall = 1'b1;
        chk("fstall_flush", {31'd0, o_flush}, 32'd1);
        step();
        i_stall = 1'b0;
        chk("fstall_gap", {31'd0, o_flush}, 32'd0);
        step();
        chk("fstall_d_cleared", {31'd0, o_flush}, 32'd0);
        chk("fstall_mis_cnt", {28'd0, o_mis_cnt}, 32'd3);

        // mispredict counter saturation
        set_ex(ADDI, 1'b0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            fetch(32'h300, 32'h500, 1'b1);
            step();
            step();
        end
        chk("mis_saturate", {28'd0, o_mis_cnt}, 32'd15);

        // back-to-back correctly predicted branches saturate the branch counter
        set_ex(BEQ, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) fetch(32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 1'b0);
        step();
        step();
        chk("br_saturate", {28'd0, o_br_cnt}, 32'd15);

        // reset in the middle of a flush
        set_ex(BNE, 1'b1, 32'h180);
        fetch(32'h200, 32'h204, 1'b0);
        step();
        chk("rst_pre_flush", {31'd0, o_flush}, 32'd1);
        i_rst = 1'b1;
        #1;
        chk("rst_flush_masked", {31'd0, o_flush}, 32'd0);
        step();
        i_rst = 1'b0;
        chk("rst_br_cnt", {28'd0, o_br_cnt}, 32'd0);
        chk("rst_mis_cnt", {28'd0, o_mis_cnt}, 32'd0);
        chk("rst_upd_pc", o_upd_pc, 32'd0);
        chk("rst_flush", {31'd0, o_flush}, 32'd0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
